// File: rtl/dom_and_nshare_if.sv
// Handshake bundle for the D-share DOM AND gadget: input shares, fresh
// randomness, and the masked product with valid/ready flow control.
interface dom_and_nshare_if #(
    parameter int D = 2
);
    localparam int RND = D * (D - 1) / 2;

    logic           in_valid;
    logic           in_ready;
    logic [D-1:0]   ina;
    logic [D-1:0]   inb;
    logic [RND-1:0] rin;
    logic           out_valid;
    logic           out_ready;
    logic [D-1:0]   out;
    logic           done;

    // Producer/consumer side that feeds operands and takes results
    modport master (
        output in_valid, ina, inb, rin, out_ready,
        input  in_ready, out_valid, out, done
    );

    // Gadget side
    modport slave (
        input  in_valid, ina, inb, rin, out_ready,
        output in_ready, out_valid, out, done
    );
endinterface

// File: rtl/dom_and_nshare.sv
// D-share domain-oriented masked AND gadget. Stage 1 registers the D*D
// partial products (cross terms blinded with fresh randomness), stage 2
// registers the per-domain XOR compression. Both stage boundaries are
// registers so glitches cannot combine shares across domains.
module dom_and_nshare #(
    parameter int D = 2
) (
    input  logic             clk,
    input  logic             rst,
    dom_and_nshare_if.slave  bus
);
    localparam int RND = D * (D - 1) / 2;

    // Cross-term registers must survive synthesis untouched: merging or
    // retiming them would reintroduce the glitch paths they exist to block.
    (* keep = "true", dont_touch = "true" *) logic [D-1:0][D-1:0] r_p;
    logic                r_v1;
    logic [D-1:0]        r_out;
    logic                r_outValid;
    logic                r_done;

    logic [D-1:0][D-1:0] w_pNext;
    logic [D-1:0]        w_comp;
    logic                w_s1Adv;
    logic                w_s2Adv;
    logic                w_inReady;

    // Partial products: diagonal terms stay inside their own domain, each
    // off-diagonal pair (i,j)/(j,i) shares one random bit so it cancels
    // when all output shares are XORed together.
    for (genvar gi = 0; gi < D; gi++) begin : gRow
        for (genvar gj = 0; gj < D; gj++) begin : gCol
            if (gi == gj) begin : gDiag
                assign w_pNext[gi][gj] = bus.ina[gi] & bus.inb[gi];
            end else begin : gCross
                localparam int LO = (gi < gj) ? gi : gj;
                localparam int HI = (gi < gj) ? gj : gi;
                localparam int K  = LO * D - LO * (LO + 1) / 2 + (HI - LO - 1);
                assign w_pNext[gi][gj] = (bus.ina[gi] & bus.inb[gj]) ^ bus.rin[K];
            end
        end
        assign w_comp[gi] = ^r_p[gi];
    end

    assign w_s2Adv   = !r_outValid || bus.out_ready;
    assign w_inReady = !r_v1 || w_s2Adv;
    assign w_s1Adv   = bus.in_valid && w_inReady;

    assign bus.in_ready  = w_inReady;
    assign bus.out_valid = r_outValid;
    assign bus.out       = r_out;
    assign bus.done      = r_done;

    // Stage 1: capture partial products only for accepted operands, and
    // track whether the stage holds a result not yet moved downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p  <= '0;
            r_v1 <= 1'b0;
        end else begin
            if (w_s1Adv) begin
                r_p <= w_pNext;
            end
            if (w_s1Adv) begin
                r_v1 <= 1'b1;
            end else if (w_s2Adv) begin
                r_v1 <= 1'b0;
            end
        end
    end

    // Stage 2: compress each domain's row; shares are zeroed whenever the
    // output is not valid so stale masked data never sits on the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out      <= '0;
            r_outValid <= 1'b0;
        end else if (w_s2Adv) begin
            if (r_v1) begin
                r_out      <= w_comp;
                r_outValid <= 1'b1;
            end else begin
                r_out      <= '0;
                r_outValid <= 1'b0;
            end
        end
    end

    // Completion pulse, one cycle after each output transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= r_outValid && bus.out_ready;
        end
    end
endmodule

// File: tb/tb_dom_and_nshare.sv
// Directed bench for the DOM AND gadget with one D=2 and one D=3 instance.
module tb_dom_and_nshare;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    dom_and_nshare_if #(.D(2)) ifc2 ();
    dom_and_nshare_if #(.D(3)) ifc3 ();

    dom_and_nshare #(.D(2)) dut2 (.clk(clk), .rst(rst), .bus(ifc2.slave));
    dom_and_nshare #(.D(3)) dut3 (.clk(clk), .rst(rst), .bus(ifc3.slave));

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset();
        @(negedge clk);
        checks++; if (ifc2.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_d2_valid: got %b expected 0", ifc2.out_valid); end
        checks++; if (ifc2.out !== 2'b00) begin errors++; $display("[TB] FAIL rst_d2_out: got %b expected 00", ifc2.out); end
        checks++; if (ifc3.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_d3_valid: got %b expected 0", ifc3.out_valid); end
        checks++; if (ifc3.done !== 1'b0) begin errors++; $display("[TB] FAIL rst_d3_done: got %b expected 0", ifc3.done); end
        rst = 1'b0;
        #1;
        checks++; if (ifc2.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_d2_inready: got %b expected 1", ifc2.in_ready); end
        checks++; if (ifc3.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_d3_inready: got %b expected 1", ifc3.in_ready); end
    endtask

    task automatic test_d2_vectors();
        logic [1:0] vA [3];
        logic [1:0] vB [3];
        logic       vR [3];
        logic [1:0] vOut [3];
        vA = '{2'b01, 2'b01, 2'b01};
        vB = '{2'b11, 2'b10, 2'b10};
        vR = '{1'b1, 1'b0, 1'b1};
        vOut = '{2'b11, 2'b01, 2'b10};
        ifc2.out_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            ifc2.ina = vA[n]; ifc2.inb = vB[n]; ifc2.rin = vR[n]; ifc2.in_valid = 1'b1;
            @(negedge clk);
            ifc2.in_valid = 1'b0;
            checks++; if (ifc2.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL d2_lat%0d: valid got %b expected 0", n, ifc2.out_valid); end
            @(negedge clk);
            checks++; if (ifc2.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL d2_valid%0d: got %b expected 1", n, ifc2.out_valid); end
            checks++; if (ifc2.out !== vOut[n]) begin errors++; $display("[TB] FAIL d2_out%0d: got %b expected %b", n, ifc2.out, vOut[n]); end
            checks++; if (ifc2.done !== 1'b0) begin errors++; $display("[TB] FAIL d2_early_done%0d: got %b expected 0", n, ifc2.done); end
            @(negedge clk);
            checks++; if (ifc2.done !== 1'b1) begin errors++; $display("[TB] FAIL d2_done%0d: got %b expected 1", n, ifc2.done); end
            checks++; if (ifc2.out_valid !== 1'b0 || ifc2.out !== 2'b00) begin errors++; $display("[TB] FAIL d2_drain%0d: got valid %b out %b expected 0/00", n, ifc2.out_valid, ifc2.out); end
            @(negedge clk);
            checks++; if (ifc2.done !== 1'b0) begin errors++; $display("[TB] FAIL d2_done_pulse%0d: got %b expected 0", n, ifc2.done); end
        end
    endtask

    task automatic test_idle_gaps();
        logic       expValid;
        logic [1:0] expOut;
        ifc2.out_ready = 1'b1;
        for (int t = 0; t < 7; t++) begin
            @(negedge clk);
            expValid = (t == 2) || (t == 5);
            expOut   = (t == 2) ? 2'b11 : ((t == 5) ? 2'b10 : 2'b00);
            checks++; if (ifc2.out_valid !== expValid) begin errors++; $display("[TB] FAIL idle_valid t%0d: got %b expected %b", t, ifc2.out_valid, expValid); end
            checks++; if (ifc2.out !== expOut) begin errors++; $display("[TB] FAIL idle_out t%0d: got %b expected %b", t, ifc2.out, expOut); end
            if (t == 0) begin
                ifc2.ina = 2'b01; ifc2.inb = 2'b11; ifc2.rin = 1'b1; ifc2.in_valid = 1'b1;
            end else if (t == 3) begin
                ifc2.ina = 2'b01; ifc2.inb = 2'b10; ifc2.rin = 1'b1; ifc2.in_valid = 1'b1;
            end else begin
                ifc2.ina = 2'b10; ifc2.inb = 2'b01; ifc2.rin = 1'b0; ifc2.in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back();
        bit   expQ [$];
        bit   expBit;
        int   doneCount;
        logic expValid;
        doneCount = 0;
        ifc3.out_ready = 1'b1;
        for (int t = 0; t < 1004; t++) begin
            @(negedge clk);
            expValid = (t >= 2) && (t < 1002);
            checks++; if (ifc3.out_valid !== expValid) begin errors++; $display("[TB] FAIL b2b_valid t%0d: got %b expected %b", t, ifc3.out_valid, expValid); end
            if (ifc3.out_valid === 1'b1 && expQ.size() > 0) begin
                expBit = expQ.pop_front();
                checks++; if ((^ifc3.out) !== expBit) begin errors++; $display("[TB] FAIL b2b_xor t%0d: got %b expected %b", t, ^ifc3.out, expBit); end
            end else if (ifc3.out_valid !== 1'b1) begin
                checks++; if (ifc3.out !== 3'b000) begin errors++; $display("[TB] FAIL b2b_zero t%0d: got %b expected 000", t, ifc3.out); end
            end
            if (ifc3.done === 1'b1) doneCount++;
            if (t < 1000) begin
                ifc3.ina = 3'($urandom_range(0, 7));
                ifc3.inb = 3'($urandom_range(0, 7));
                ifc3.rin = 3'($urandom_range(0, 7));
                ifc3.in_valid = 1'b1;
                expQ.push_back((^ifc3.ina) & (^ifc3.inb));
            end else begin
                ifc3.in_valid = 1'b0;
            end
        end
        checks++; if (doneCount != 1000) begin errors++; $display("[TB] FAIL b2b_done_count: got %0d expected 1000", doneCount); end
        checks++; if (expQ.size() != 0) begin errors++; $display("[TB] FAIL b2b_leftover: got %0d expected 0", expQ.size()); end
    endtask

    task automatic test_backpressure();
        logic [2:0] saved;
        @(negedge clk);
        ifc3.out_ready = 1'b0;
        ifc3.ina = 3'b100; ifc3.inb = 3'b111; ifc3.rin = 3'b101; ifc3.in_valid = 1'b1;
        @(negedge clk);
        ifc3.ina = 3'b110; ifc3.inb = 3'b001; ifc3.rin = 3'b010; ifc3.in_valid = 1'b1;
        @(negedge clk);
        ifc3.in_valid = 1'b0;
        checks++; if (ifc3.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_fill_valid: got %b expected 1", ifc3.out_valid); end
        checks++; if ((^ifc3.out) !== 1'b1) begin errors++; $display("[TB] FAIL bp_first_xor: got %b expected 1", ^ifc3.out); end
        saved = ifc3.out;
        ifc3.ina = 3'b111; ifc3.inb = 3'b111; ifc3.rin = 3'b000; ifc3.in_valid = 1'b1;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            checks++; if (ifc3.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_hold_valid s%0d: got %b expected 1", s, ifc3.out_valid); end
            checks++; if (ifc3.out !== saved) begin errors++; $display("[TB] FAIL bp_hold_out s%0d: got %b expected %b", s, ifc3.out, saved); end
            checks++; if (ifc3.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_inready s%0d: got %b expected 0", s, ifc3.in_ready); end
            if (s == 4) begin
                ifc3.in_valid = 1'b0;
                ifc3.out_ready = 1'b1;
            end
        end
        @(negedge clk);
        checks++; if (ifc3.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_second_valid: got %b expected 1", ifc3.out_valid); end
        checks++; if ((^ifc3.out) !== 1'b0) begin errors++; $display("[TB] FAIL bp_second_xor: got %b expected 0", ^ifc3.out); end
        checks++; if (ifc3.done !== 1'b1) begin errors++; $display("[TB] FAIL bp_done1: got %b expected 1", ifc3.done); end
        @(negedge clk);
        checks++; if (ifc3.out_valid !== 1'b0 || ifc3.out !== 3'b000) begin errors++; $display("[TB] FAIL bp_empty: got valid %b out %b expected 0/000", ifc3.out_valid, ifc3.out); end
        checks++; if (ifc3.done !== 1'b1) begin errors++; $display("[TB] FAIL bp_done2: got %b expected 1", ifc3.done); end
        @(negedge clk);
        checks++; if (ifc3.out_valid !== 1'b0 || ifc3.done !== 1'b0) begin errors++; $display("[TB] FAIL bp_no_dup: got valid %b done %b expected 0/0", ifc3.out_valid, ifc3.done); end
    endtask

    task automatic test_reset_midstream();
        ifc3.out_ready = 1'b1;
        @(negedge clk);
        ifc3.ina = 3'b111; ifc3.inb = 3'b111; ifc3.rin = 3'b110; ifc3.in_valid = 1'b1;
        @(negedge clk);
        ifc3.ina = 3'b011; ifc3.inb = 3'b100; ifc3.rin = 3'b001; ifc3.in_valid = 1'b1;
        @(negedge clk);
        ifc3.in_valid = 1'b0;
        checks++; if ((^ifc3.out) !== 1'b1 || ifc3.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL mid_pre: got valid %b xor %b expected 1/1", ifc3.out_valid, ^ifc3.out); end
        @(negedge clk);
        checks++; if (ifc3.done !== 1'b1 || ifc3.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL mid_inflight: got done %b valid %b expected 1/1", ifc3.done, ifc3.out_valid); end
        rst = 1'b1;
        #1;
        checks++; if (ifc3.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_valid: got %b expected 0", ifc3.out_valid); end
        checks++; if (ifc3.out !== 3'b000) begin errors++; $display("[TB] FAIL mid_rst_out: got %b expected 000", ifc3.out); end
        checks++; if (ifc3.done !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_done: got %b expected 0", ifc3.done); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (ifc3.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_release_ready: got %b expected 1", ifc3.in_ready); end
        @(negedge clk);
        checks++; if (ifc3.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_flushed: got %b expected 0", ifc3.out_valid); end
        ifc3.ina = 3'b010; ifc3.inb = 3'b100; ifc3.rin = 3'b011; ifc3.in_valid = 1'b1;
        @(negedge clk);
        ifc3.in_valid = 1'b0;
        checks++; if (ifc3.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_new_lat: got %b expected 0", ifc3.out_valid); end
        @(negedge clk);
        checks++; if (ifc3.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL mid_new_valid: got %b expected 1", ifc3.out_valid); end
        checks++; if ((^ifc3.out) !== 1'b1) begin errors++; $display("[TB] FAIL mid_new_xor: got %b expected 1", ^ifc3.out); end
        @(negedge clk);
        checks++; if (ifc3.done !== 1'b1 || ifc3.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_new_done: got done %b valid %b expected 1/0", ifc3.done, ifc3.out_valid); end
    endtask

    // Scenario sequence
    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        ifc2.in_valid = 1'b0; ifc2.ina = '0; ifc2.inb = '0; ifc2.rin = '0; ifc2.out_ready = 1'b1;
        ifc3.in_valid = 1'b0; ifc3.ina = '0; ifc3.inb = '0; ifc3.rin = '0; ifc3.out_ready = 1'b1;
        test_reset();
        test_d2_vectors();
        test_idle_gaps();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
